// File: rtl/snn_ff_pkg.sv
// Shared constants, state encodings and helpers for the synaptic access path.
package snn_ff_pkg;

    // Default network geometry.
    localparam int INPUT_NEURON         = 784;
    localparam int OUTPUT_NEURON        = 256;
    localparam int POST_NEUR_PARALLEL   = 4;
    localparam int PRE_NEUR_ADDR_WIDTH  = 10;
    localparam int POST_NEUR_ADDR_WIDTH = 10;
    localparam int SYN_ARRAY_ADDR_WIDTH = 16;

    // Number of SRAM words per weight row.
    localparam int GROUPS = OUTPUT_NEURON / POST_NEUR_PARALLEL;

    // Sequencer state encodings.
    localparam int         STATE_WIDTH = 3;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INF_RD   = 3'd1;
    localparam logic [2:0] ST_INF_LAST = 3'd2;
    localparam logic [2:0] ST_TR_RD    = 3'd3;
    localparam logic [2:0] ST_TR_WB    = 3'd4;
    localparam logic [2:0] ST_FIN      = 3'd5;

    typedef enum logic [STATE_WIDTH-1:0] {
        S_IDLE     = ST_IDLE,
        S_INF_RD   = ST_INF_RD,
        S_INF_LAST = ST_INF_LAST,
        S_TR_RD    = ST_TR_RD,
        S_TR_WB    = ST_TR_WB,
        S_FIN      = ST_FIN
    } seq_state_t;

    // Ceil-log2 with a floor of 1 bit, used to size the group counter.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/synaptic_access_sequencer_if.sv
// Bundle between the event source / SRAM bank / neuron core and the sequencer.
//
// Event handshake: the source raises EVT_VALID with EVT_PRE_ADDR and IS_TRAIN
// stable; the event is taken on a rising edge where EVT_VALID and EVT_READY are
// both 1. EVT_READY never depends on EVT_VALID, and there is no queueing: while
// EVT_READY is 0 the request is simply left pending.
interface synaptic_access_sequencer_if #(
    parameter int PRE_W  = 10,
    parameter int SYN_W  = 16,
    parameter int POST_W = 10
) ();

    logic              EVT_VALID;
    logic              EVT_READY;
    logic [PRE_W-1:0]  EVT_PRE_ADDR;
    logic              IS_TRAIN;
    logic              SPI_GATE_ACTIVITY_sync;

    logic              CTRL_SYNARRAY_CS;
    logic              CTRL_SYNARRAY_WE;
    logic [SYN_W-1:0]  CTRL_SYNARRAY_ADDR;
    logic [POST_W-1:0] CTRL_POST_NEURON_ADDRESS;
    logic              SYN_RDATA_VALID;
    logic              BUSY;
    logic              DONE;
    logic [2:0]        STATE_DBG;

    // Sequencer side.
    modport master (
        input  EVT_VALID, EVT_PRE_ADDR, IS_TRAIN, SPI_GATE_ACTIVITY_sync,
        output EVT_READY, CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_SYNARRAY_ADDR,
        output CTRL_POST_NEURON_ADDRESS, SYN_RDATA_VALID, BUSY, DONE, STATE_DBG
    );

    // Event source / SRAM / neuron core side.
    modport slave (
        output EVT_VALID, EVT_PRE_ADDR, IS_TRAIN, SPI_GATE_ACTIVITY_sync,
        input  EVT_READY, CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_SYNARRAY_ADDR,
        input  CTRL_POST_NEURON_ADDRESS, SYN_RDATA_VALID, BUSY, DONE, STATE_DBG
    );

endinterface

// File: rtl/syn_row_addr_gen.sv
// Row address generator: holds the row base, walks the group counter and
// produces the read-data-valid / post-neuron address pair one cycle after
// each SRAM read, matching the bank's 1-cycle read latency.
module syn_row_addr_gen
    import snn_ff_pkg::*;
#(
    parameter int N_GROUPS = GROUPS,
    parameter int PARALLEL = POST_NEUR_PARALLEL,
    parameter int PRE_W    = PRE_NEUR_ADDR_WIDTH,
    parameter int SYN_W    = SYN_ARRAY_ADDR_WIDTH,
    parameter int POST_W   = POST_NEUR_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [PRE_W-1:0]  pre_addr,
    input  logic              step,
    input  logic              rd_issued,
    output logic [SYN_W-1:0]  syn_addr,
    output logic              last_group,
    output logic              rdata_valid,
    output logic [POST_W-1:0] post_addr
);

    localparam int             GW     = clog2_min1(N_GROUPS);
    localparam logic [GW-1:0]  G_LAST = GW'(N_GROUPS - 1);

    logic [SYN_W-1:0] base_q;
    logic [GW-1:0]    g_q;

    // Capture the row base on accept and advance the group counter on request.
    // The counter is never stepped past the last group, so it only returns to
    // zero on the next accept and the address never wraps inside a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            g_q    <= '0;
        end else if (load) begin
            base_q <= SYN_W'(pre_addr) * SYN_W'(N_GROUPS);
            g_q    <= '0;
        end else if (step) begin
            g_q    <= g_q + GW'(1);
        end
    end

    // Address is base plus counter; it stays stable whenever CS is low.
    assign syn_addr   = base_q + SYN_W'(g_q);
    assign last_group = (g_q == G_LAST);

    // Delay the read strobe and its group by one cycle so they line up with Q.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_valid <= 1'b0;
            post_addr   <= '0;
        end else begin
            rdata_valid <= rd_issued;
            post_addr   <= POST_W'(g_q) * POST_W'(PARALLEL);
        end
    end

endmodule

// File: rtl/synaptic_access_sequencer.sv
// Initiator for the synaptic-array port: accepts one pre-neuron event at a
// time and walks all weight groups of its row, either as a pipelined read
// stream (inference) or as read/write-back pairs (training).
module synaptic_access_sequencer
    import snn_ff_pkg::*;
#(
    parameter int N_INPUT_NEURON  = INPUT_NEURON,
    parameter int N_OUTPUT_NEURON = OUTPUT_NEURON,
    parameter int PARALLEL        = POST_NEUR_PARALLEL,
    parameter int PRE_W           = PRE_NEUR_ADDR_WIDTH,
    parameter int POST_W          = POST_NEUR_ADDR_WIDTH,
    parameter int SYN_W           = SYN_ARRAY_ADDR_WIDTH
) (
    input  logic                         CLK,
    input  logic                         RST,
    synaptic_access_sequencer_if.master  bus
);

    localparam int N_GROUPS = N_OUTPUT_NEURON / PARALLEL;

    seq_state_t state;
    logic       cs_q;
    logic       we_q;
    logic       busy_q;
    logic       done_q;

    logic       ready;
    logic       accept;
    logic       in_range;
    logic       step;
    logic       rd_issued;
    logic       last_group;

    logic [SYN_W-1:0]  syn_addr;
    logic              rdata_valid;
    logic [POST_W-1:0] post_addr;

    // IDLE is the only acceptance point; the gate only blocks new events.
    assign ready    = (state == S_IDLE) & ~bus.SPI_GATE_ACTIVITY_sync;
    assign accept   = bus.EVT_VALID & ready;
    assign in_range = int'(bus.EVT_PRE_ADDR) < N_INPUT_NEURON;

    // Advance the counter after each inference read and after each write-back,
    // except on the final group of the row.
    assign step      = ((state == S_INF_RD) | (state == S_TR_WB)) & ~last_group;
    // A read is any cycle with the bank selected and write disabled.
    assign rd_issued = cs_q & ~we_q;

    syn_row_addr_gen #(
        .N_GROUPS (N_GROUPS),
        .PARALLEL (PARALLEL),
        .PRE_W    (PRE_W),
        .SYN_W    (SYN_W),
        .POST_W   (POST_W)
    ) u_addr_gen (
        .clk         (CLK),
        .rst         (RST),
        .load        (accept),
        .pre_addr    (bus.EVT_PRE_ADDR),
        .step        (step),
        .rd_issued   (rd_issued),
        .syn_addr    (syn_addr),
        .last_group  (last_group),
        .rdata_valid (rdata_valid),
        .post_addr   (post_addr)
    );

    // Row sequencer; CS/WE/BUSY/DONE are registered alongside the state so
    // each output reflects the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            cs_q   <= 1'b0;
            we_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        we_q   <= 1'b0;
                        if (!in_range) begin
                            // Out-of-range row: no SRAM traffic, finish at once.
                            state  <= S_FIN;
                            cs_q   <= 1'b0;
                            done_q <= 1'b1;
                        end else if (bus.IS_TRAIN) begin
                            state <= S_TR_RD;
                            cs_q  <= 1'b1;
                        end else begin
                            state <= S_INF_RD;
                            cs_q  <= 1'b1;
                        end
                    end
                end
                S_INF_RD: begin
                    if (last_group) begin
                        state <= S_INF_LAST;
                        cs_q  <= 1'b0;
                    end
                end
                S_INF_LAST: begin
                    // Only the delayed valid for the last group remains.
                    state  <= S_FIN;
                    done_q <= 1'b1;
                end
                S_TR_RD: begin
                    state <= S_TR_WB;
                    we_q  <= 1'b1;
                end
                S_TR_WB: begin
                    we_q <= 1'b0;
                    if (last_group) begin
                        state  <= S_FIN;
                        cs_q   <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state <= S_TR_RD;
                    end
                end
                S_FIN: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    cs_q   <= 1'b0;
                    we_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.EVT_READY                = ready;
    assign bus.CTRL_SYNARRAY_CS         = cs_q;
    assign bus.CTRL_SYNARRAY_WE         = we_q;
    assign bus.CTRL_SYNARRAY_ADDR       = syn_addr;
    assign bus.CTRL_POST_NEURON_ADDRESS = post_addr;
    assign bus.SYN_RDATA_VALID          = rdata_valid;
    assign bus.BUSY                     = busy_q;
    assign bus.DONE                     = done_q;
    assign bus.STATE_DBG                = state;

endmodule

// File: tb/tb_synaptic_access_sequencer.sv
// Bench for synaptic_access_sequencer with a word-addressed SRAM model and a
// feed-forward STDP stand-in for the neuron core's write-back data.
module tb_synaptic_access_sequencer;
    import snn_ff_pkg::*;

    localparam int GR        = GROUPS;
    localparam int MEM_WORDS = INPUT_NEURON * GROUPS;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    synaptic_access_sequencer_if #(
        .PRE_W  (PRE_NEUR_ADDR_WIDTH),
        .SYN_W  (SYN_ARRAY_ADDR_WIDTH),
        .POST_W (POST_NEUR_ADDR_WIDTH)
    ) bus ();

    synaptic_access_sequencer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // ---------------- SRAM bank + core model ----------------
    logic [31:0] mem [0:MEM_WORDS-1];
    logic [31:0] sram_q;
    logic [31:0] orig [0:GR-1];

    // Potentiate each of the four 8-bit weights by 3, saturating at 255.
    function automatic logic [31:0] ffstdp(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = (w[i*8 +: 8] >= 8'd252) ? 8'd255 : w[i*8 +: 8] + 8'd3;
        end
        return r;
    endfunction

    always @(posedge CLK) begin
        if (bus.CTRL_SYNARRAY_CS === 1'b1) begin
            if (bus.CTRL_SYNARRAY_WE === 1'b1) mem[bus.CTRL_SYNARRAY_ADDR] = ffstdp(sram_q);
            else sram_q <= mem[bus.CTRL_SYNARRAY_ADDR];
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int row_id = 0;
    int last_wait = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic cs, input logic we, input logic val,
                                         input logic done, input logic [15:0] addr,
                                         input logic [9:0] post, input logic unk);
        return {33'b0, cs, we, val, done, (cs ? addr : 16'h0), (val ? post : 10'h0), unk};
    endfunction

    function automatic logic [63:0] obs_pack();
        return pack(bus.CTRL_SYNARRAY_CS, bus.CTRL_SYNARRAY_WE, bus.SYN_RDATA_VALID, bus.DONE,
                    bus.CTRL_SYNARRAY_ADDR, bus.CTRL_POST_NEURON_ADDRESS,
                    $isunknown(bus.CTRL_SYNARRAY_ADDR));
    endfunction

    // ---------------- driver: one event, checked cycle by cycle ----------------
    // Called at a falling edge. k counts cycles after the accept cycle.
    task automatic run_row(input int pre, input bit train, input bit hold_valid,
                           input int gate_at_k, input int rst_at_k);
        bit oor;
        bit rst_seen;
        int kdone;
        int base;
        int waited;
        int nwr;
        int g;
        logic e_cs, e_we, e_val, e_done, e_ready;
        logic [15:0] e_addr;
        logic [9:0]  e_post;

        row_id++;
        oor   = (pre >= INPUT_NEURON);
        kdone = oor ? 1 : (train ? 2 * GR + 1 : GR + 2);
        base  = pre * GR;
        if (!oor) for (int i = 0; i < GR; i++) orig[i] = mem[base + i];

        bus.EVT_PRE_ADDR = 10'(pre);
        bus.IS_TRAIN     = train;
        bus.EVT_VALID    = 1'b1;
        waited = 0;
        while (bus.EVT_READY !== 1'b1 && waited < 300) begin
            @(negedge CLK);
            waited++;
        end
        last_wait = waited;
        check($sformatf("row%0d_accept_timeout", row_id), 64'(waited >= 300), 64'd0);
        if (waited >= 300) begin
            bus.EVT_VALID = 1'b0;
            return;
        end

        rst_seen = 1'b0;
        for (int k = 1; k <= kdone + 1; k++) begin
            @(negedge CLK);
            if (k == 1 && !hold_valid) bus.EVT_VALID = 1'b0;

            e_cs = 0; e_we = 0; e_val = 0; e_done = 0; e_addr = '0; e_post = '0;
            if (!rst_seen) begin
                if (oor) begin
                    e_done = (k == 1);
                end else if (!train) begin
                    if (k <= GR) begin e_cs = 1; e_addr = 16'(base + k - 1); end
                    if (k >= 2 && k <= GR + 1) begin e_val = 1; e_post = 10'((k - 2) * POST_NEUR_PARALLEL); end
                    e_done = (k == GR + 2);
                end else begin
                    if (k <= 2 * GR) begin
                        g      = (k - 1) / 2;
                        e_cs   = 1;
                        e_addr = 16'(base + g);
                        e_we   = (k % 2 == 0);
                        e_val  = e_we;
                        e_post = 10'(g * POST_NEUR_PARALLEL);
                    end
                    e_done = (k == 2 * GR + 1);
                end
                e_ready = (k > kdone) && !bus.SPI_GATE_ACTIVITY_sync;
            end else begin
                e_ready = !bus.SPI_GATE_ACTIVITY_sync;
            end

            check($sformatf("row%0d_k%0d_bus", row_id, k), obs_pack(),
                  pack(e_cs, e_we, e_val, e_done, e_addr, e_post, 1'b0));
            check($sformatf("row%0d_k%0d_ready", row_id, k), 64'(bus.EVT_READY), 64'(e_ready));
            if (rst_seen || k > kdone)
                check($sformatf("row%0d_k%0d_busy", row_id, k), 64'(bus.BUSY), 64'd0);
            else if (k < kdone)
                check($sformatf("row%0d_k%0d_busy", row_id, k), 64'(bus.BUSY), 64'd1);

            if (k == gate_at_k) bus.SPI_GATE_ACTIVITY_sync = 1'b1;
            if (k == rst_at_k + 1) RST = 1'b0;
            if (k == rst_at_k) begin RST = 1'b1; rst_seen = 1'b1; end
        end

        if (!oor) begin
            nwr = !train ? 0 : ((rst_at_k > 0) ? (rst_at_k - 1) / 2 : GR);
            for (int i = 0; i < GR; i++) begin
                check($sformatf("row%0d_mem_g%0d", row_id, i), 64'(mem[base + i]),
                      64'((i < nwr) ? ffstdp(orig[i]) : orig[i]));
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int pre;
        bit train;
        bit hold;

        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        sram_q = '0;
        bus.EVT_VALID              = 1'b0;
        bus.EVT_PRE_ADDR           = '0;
        bus.IS_TRAIN               = 1'b0;
        bus.SPI_GATE_ACTIVITY_sync = 1'b1;
        RST = 1'b1;

        // Reset with gate high: all outputs low, ready low.
        repeat (3) @(negedge CLK);
        check("reset_gated_bus", obs_pack(), pack(0, 0, 0, 0, 16'h0, 10'h0, 1'b0));
        check("reset_gated_ready", 64'(bus.EVT_READY), 64'd0);
        check("reset_busy", 64'(bus.BUSY), 64'd0);
        bus.SPI_GATE_ACTIVITY_sync = 1'b0;
        #1;
        check("reset_ready", 64'(bus.EVT_READY), 64'd1);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("idle_bus", obs_pack(), pack(0, 0, 0, 0, 16'h0, 10'h0, 1'b0));
        check("idle_addr_zero", 64'(bus.CTRL_SYNARRAY_ADDR), 64'd0);
        check("idle_ready", 64'(bus.EVT_READY), 64'd1);

        // Inference row 3: addresses 192..255, DONE in cycle 66.
        run_row(3, 1'b0, 1'b0, -5, -5);
        // Training row 783: addresses 50112..50175, DONE in cycle 129.
        run_row(783, 1'b1, 1'b0, -5, -5);
        // Out-of-range row.
        run_row(800, 1'b0, 1'b0, -5, -5);

        // Back-to-back with EVT_VALID held high across the first row.
        run_row(5, 1'b0, 1'b1, -5, -5);
        run_row(17, 1'b1, 1'b0, -5, -5);
        check("b2b_accept_cycle_after_done", 64'(last_wait), 64'd0);

        // Gate raised at training group 10 read: row completes, no new accept.
        run_row(100, 1'b1, 1'b0, 21, -5);
        bus.EVT_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check($sformatf("gate_hold%0d_ready", i), 64'(bus.EVT_READY), 64'd0);
            check($sformatf("gate_hold%0d_busy_cs", i), 64'({bus.BUSY, bus.CTRL_SYNARRAY_CS}), 64'd0);
        end
        bus.EVT_VALID = 1'b0;
        bus.SPI_GATE_ACTIVITY_sync = 1'b0;
        #1;
        check("gate_release_ready", 64'(bus.EVT_READY), 64'd1);
        @(negedge CLK);

        // Reset during the read of training group 20: groups >= 20 untouched.
        run_row(400, 1'b1, 1'b0, -5, 41);

        // Randomized events.
        for (int n = 0; n < 8; n++) begin
            pre = $urandom_range(0, INPUT_NEURON - 1);
            if ($urandom_range(0, 4) == 0) pre = $urandom_range(INPUT_NEURON, 1023);
            train = 1'($urandom_range(0, 1));
            hold  = 1'($urandom_range(0, 1));
            run_row(pre, train, hold, -5, -5);
        end
        bus.EVT_VALID = 1'b0;
        repeat (2) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
